// File: rtl/mult_pkg.sv
// Shared constants and state encoding for the shift-and-add multiplier.
package mult_pkg;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned PROD_W = 2 * WIDTH;

    // Counter value seen on the final (16th) iteration edge
    localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/CLA_16bit_ripple.sv
// 16-bit adder built from four 4-bit carry-lookahead groups with rippled group carries.
module CLA_16bit_ripple (
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    logic [15:0] p;
    logic [15:0] g;
    logic [16:0] c;

    assign p = A ^ B;
    assign g = A & B;

    // Lookahead carries inside each group; group carry-out feeds the next group
    always_comb begin
        c    = '0;
        c[0] = cin;
        for (int k = 0; k < 4; k++) begin
            c[4*k+1] = g[4*k]
                     | (p[4*k] & c[4*k]);
            c[4*k+2] = g[4*k+1]
                     | (p[4*k+1] & g[4*k])
                     | (p[4*k+1] & p[4*k] & c[4*k]);
            c[4*k+3] = g[4*k+2]
                     | (p[4*k+2] & g[4*k+1])
                     | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
            c[4*k+4] = g[4*k+3]
                     | (p[4*k+3] & g[4*k+2])
                     | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
        end
    end

    assign sum  = p ^ c[15:0];
    assign cout = c[16];

endmodule

// File: rtl/shift_add_multiplier_16.sv
// Sequential unsigned 16x16->32 multiplier: one CLA partial-product add and right shift per cycle.
module shift_add_multiplier_16
    import mult_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    output logic              busy,
    output logic              done,
    output logic [PROD_W-1:0] product
);

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    mcand_q, mcand_d;
    // High accumulator half is {cy_q, acc_hi_q}: the captured carry is its MSB
    logic                cy_q, cy_d;
    logic [WIDTH-2:0]    acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0]    acc_lo_q, acc_lo_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PROD_W-1:0]   product_q, product_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [WIDTH-1:0]    cla_a_c;
    logic [WIDTH-1:0]    addend_c;
    logic [WIDTH-1:0]    sum_c;
    logic                cout_c;

    // Partial product selected by the current multiplier LSB
    assign cla_a_c  = {cy_q, acc_hi_q};
    assign addend_c = acc_lo_q[0] ? mcand_q : '0;

    CLA_16bit_ripple u_cla (
        .A    (cla_a_c),
        .B    (addend_c),
        .cin  (1'b0),
        .sum  (sum_c),
        .cout (cout_c)
    );

    // Next-state, datapath update and registered output decode
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        cy_d      = cy_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        cnt_d     = cnt_q;
        product_d = product_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d  = a;
                    cy_d     = 1'b0;
                    acc_hi_d = '0;
                    acc_lo_d = b;
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                // {cout, sum, acc_lo} shifted right by one
                cy_d     = cout_c;
                acc_hi_d = sum_c[WIDTH-1:1];
                acc_lo_d = {sum_c[0], acc_lo_q[WIDTH-1:1]};
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == ITER_LAST) begin
                    product_d = {cout_c, sum_c, acc_lo_q[WIDTH-1:1]};
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            mcand_q   <= '0;
            cy_q      <= 1'b0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            cy_q      <= cy_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_shift_add_multiplier_16.sv
// Scoreboard bench for shift_add_multiplier_16 using directed operand vectors.
module tb_shift_add_multiplier_16;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] a     = '0;
    logic [15:0] b     = '0;
    logic        busy;
    logic        done;
    logic [31:0] product;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int cyc      = 0;

    logic [31:0] exp_q[$];

    shift_add_multiplier_16 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Monitor: every done pulse pops the oldest expected product
    always @(negedge clk) begin
        logic [31:0] e;
        if (rst_n && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("product", product, e);
            end
        end
    end

    task automatic issue(input logic [15:0] x, input logic [15:0] y);
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Waits (bounded) for done; counts cycles since acceptance and busy cycles
    task automatic wait_done(output int lat, output int bcnt, output logic hold_ok,
                             input logic [31:0] hold_val);
        bit seen;
        lat     = 0;
        bcnt    = 0;
        hold_ok = 1'b1;
        seen    = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (busy === 1'b1) bcnt++;
            if (done === 1'b1) begin
                lat  = n;
                seen = 1;
                break;
            end
            if (product !== hold_val) hold_ok = 1'b0;
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_op(input logic [15:0] x, input logic [15:0] y,
                         input logic [31:0] e, input string nm);
        logic [31:0] prev;
        int          lat;
        int          bc;
        logic        hok;
        prev = product;
        exp_q.push_back(e);
        issue(x, y);
        wait_done(lat, bc, hok, prev);
        check({nm, "_latency"}, 32'(lat), 32'd17);
        check({nm, "_busy_cycles"}, 32'(bc), 32'd17);
        check({nm, "_hold"}, 32'(hok), 32'd1);
        @(negedge clk);
        check({nm, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          bc;
        int          last;
        logic        hok;
        bit          seen;
        logic [15:0] va[5];
        logic [15:0] vb[5];
        logic [31:0] ve[5];

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_product", product, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic operations and boundaries
        do_op(16'd5, 16'd9, 32'd45, "op_5x9");
        do_op(16'hFFFF, 16'hFFFF, 32'hFFFE0001, "op_max");
        do_op(16'h0000, 16'h1234, 32'd0, "op_zero_a");
        do_op(16'h1234, 16'h0000, 32'd0, "op_zero_b");
        do_op(16'd5, 16'd9, 32'd45, "op_5x9_again");

        // Starts during RUN and DONE are ignored; start in the next IDLE is taken
        exp_q.push_back(32'd4551);
        issue(16'd111, 16'd41);
        repeat (4) @(posedge clk);
        #1;
        a = 16'd2; b = 16'd3; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat, bc, hok, 32'd45);
        check("ign_run_latency", 32'(lat), 32'd12);
        a = 16'd2; b = 16'd3; start = 1'b1;
        @(posedge clk);
        #1;
        check("ign_done_busy", 32'(busy), 32'd0);
        exp_q.push_back(32'd6);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("restart_busy", 32'(busy), 32'd1);
        wait_done(lat, bc, hok, 32'd4551);
        check("restart_latency", 32'(lat), 32'd17);
        check("restart_hold", 32'(hok), 32'd1);
        @(negedge clk);

        // Reset at iteration 8 aborts with no result
        issue(16'd15, 16'd9);
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_product", product, 32'd0);
        rst_n = 1'b1;
        seen = 0;
        for (int n = 0; n < 25; n++) begin
            @(negedge clk);
            if (done !== 1'b0) seen = 1;
        end
        check("abort_no_done", 32'(seen), 32'd0);
        do_op(16'd15, 16'd9, 32'd135, "op_after_abort");

        // Back-to-back with start held high
        va[0] = 16'd3;     vb[0] = 16'd7;     ve[0] = 32'd21;
        va[1] = 16'h00FF;  vb[1] = 16'h0101;  ve[1] = 32'h0000FFFF;
        va[2] = 16'h8000;  vb[2] = 16'd2;     ve[2] = 32'h00010000;
        va[3] = 16'd1000;  vb[3] = 16'd1000;  ve[3] = 32'd1000000;
        va[4] = 16'hFFFF;  vb[4] = 16'd1;     ve[4] = 32'h0000FFFF;
        a = va[0]; b = vb[0]; start = 1'b1;
        exp_q.push_back(ve[0]);
        last = -1;
        for (int k = 0; k < 5; k++) begin
            seen = 0;
            for (int n = 0; n < 40; n++) begin
                @(negedge clk);
                if (done === 1'b1) begin
                    seen = 1;
                    break;
                end
            end
            if (!seen) begin
                check("b2b_timeout", 32'd0, 32'd1);
                break;
            end
            if (last >= 0) check("b2b_period", 32'(cyc - last), 32'd18);
            last = cyc;
            if (k < 4) begin
                a = va[k+1];
                b = vb[k+1];
                exp_q.push_back(ve[k+1]);
            end else begin
                start = 1'b0;
            end
        end

        repeat (3) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
